// File: rtl/sort_pkg.sv
// sort_pkg: shared state type and counter sizing for the sort datapath.
//   merge_state_t : MERGE (both streams live), DRAIN0/DRAIN1 (only that stream left)
//   cnt_w(n)      : bits needed to count 0..n inclusive
package sort_pkg;
   typedef enum logic [1:0] {MERGE, DRAIN0, DRAIN1} merge_state_t;
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/sort_merge_head.sv
// sort_merge_head: one-entry input head register with per-sequence accept limit.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_val/o_rdy/i_msg    : upstream val/rdy stream
//   i_emit               : head is moved to the output register this cycle
//   i_clr                : sequence end, re-arms the accept counter
//   o_head_val/o_head_msg: current head contents
module sort_merge_head
   import sort_pkg::*;
#(
   parameter int P_NBITS = 8,
   parameter int P_NMSGS = 4
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_val,
   output logic               o_rdy,
   input  logic [P_NBITS-1:0] i_msg,
   input  logic               i_emit,
   input  logic               i_clr,
   output logic               o_head_val,
   output logic [P_NBITS-1:0] o_head_msg
);
   localparam int CW = cnt_w(P_NMSGS);
   logic               r_val;
   logic [P_NBITS-1:0] r_msg;
   logic [CW-1:0]      r_acc;
   logic               w_acc;
   // refill allowed in the same cycle the head leaves, so this follows out_rdy combinationally
   assign o_rdy      = (!r_val || i_emit) && (r_acc < CW'(P_NMSGS));
   assign w_acc      = i_val && o_rdy;
   assign o_head_val = r_val;
   assign o_head_msg = r_msg;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_val <= 1'b0;
         r_msg <= '0;
         r_acc <= '0;
      end else begin
         if (w_acc) begin
            r_val <= 1'b1;
            r_msg <= i_msg;
         end else if (i_emit) begin
            r_val <= 1'b0;
         end
         // the last emit of a sequence never coincides with an accept
         r_acc <= i_clr ? '0 : r_acc + CW'(w_acc);
      end
   end
endmodule

// File: rtl/sort_merge_unit.sv
// sort_merge_unit: two-way streaming merge of ascending runs of P_NMSGS each.
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_in0_val/o_in0_rdy/i_in0_msg : sorted input stream 0
//   i_in1_val/o_in1_rdy/i_in1_msg : sorted input stream 1
//   o_out_val/i_out_rdy/o_out_msg : merged sorted output stream (2*P_NMSGS per sequence)
module sort_merge_unit
   import sort_pkg::*;
#(
   parameter int P_NBITS = 8,
   parameter int P_NMSGS = 4
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_in0_val,
   output logic               o_in0_rdy,
   input  logic [P_NBITS-1:0] i_in0_msg,
   input  logic               i_in1_val,
   output logic               o_in1_rdy,
   input  logic [P_NBITS-1:0] i_in1_msg,
   output logic               o_out_val,
   input  logic               i_out_rdy,
   output logic [P_NBITS-1:0] o_out_msg
);
   localparam int CW = cnt_w(P_NMSGS);
   localparam int TW = cnt_w(2 * P_NMSGS);
   merge_state_t       r_state;
   logic [CW-1:0]      r_emit0, r_emit1;
   logic               r_out_val;
   logic [P_NBITS-1:0] r_out_msg;
   logic               w_h0_val, w_h1_val, w_load, w_emit0, w_emit1, w_last;
   logic [P_NBITS-1:0] w_h0_msg, w_h1_msg;
   logic [TW-1:0]      w_total;
   sort_merge_head #(.P_NBITS(P_NBITS), .P_NMSGS(P_NMSGS)) u_head0 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_val(i_in0_val), .o_rdy(o_in0_rdy), .i_msg(i_in0_msg),
      .i_emit(w_emit0), .i_clr(w_last), .o_head_val(w_h0_val), .o_head_msg(w_h0_msg)
   );
   sort_merge_head #(.P_NBITS(P_NBITS), .P_NMSGS(P_NMSGS)) u_head1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_val(i_in1_val), .o_rdy(o_in1_rdy), .i_msg(i_in1_msg),
      .i_emit(w_emit1), .i_clr(w_last), .o_head_val(w_h1_val), .o_head_msg(w_h1_msg)
   );
   assign w_load  = !r_out_val || i_out_rdy;
   // ties go to stream 0, so the comparison is <= for head 0 and strict > for head 1
   assign w_emit0 = w_load && w_h0_val &&
                    (r_state == DRAIN0 || (r_state == MERGE && w_h1_val && w_h0_msg <= w_h1_msg));
   assign w_emit1 = w_load && w_h1_val &&
                    (r_state == DRAIN1 || (r_state == MERGE && w_h0_val && w_h0_msg > w_h1_msg));
   assign w_total = TW'(r_emit0) + TW'(r_emit1);
   assign w_last  = (w_emit0 || w_emit1) && (w_total == TW'(2 * P_NMSGS - 1));
   assign o_out_val = r_out_val;
   assign o_out_msg = r_out_msg;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= MERGE;
         r_emit0   <= '0;
         r_emit1   <= '0;
         r_out_val <= 1'b0;
         r_out_msg <= '0;
      end else begin
         if (w_load) r_out_val <= w_emit0 || w_emit1;
         if (w_emit0 || w_emit1) r_out_msg <= w_emit0 ? w_h0_msg : w_h1_msg;
         if (w_last) begin
            r_state <= MERGE;
            r_emit0 <= '0;
            r_emit1 <= '0;
         end else begin
            r_emit0 <= r_emit0 + CW'(w_emit0);
            r_emit1 <= r_emit1 + CW'(w_emit1);
            // once one stream has given its full run, the other drains unconditionally
            if (r_state == MERGE && w_emit0 && r_emit0 == CW'(P_NMSGS - 1)) r_state <= DRAIN1;
            else if (r_state == MERGE && w_emit1 && r_emit1 == CW'(P_NMSGS - 1)) r_state <= DRAIN0;
         end
      end
   end
endmodule
